rr_grant_queue: RTL and testbench

- Decoupled buffer directly downstream of the 4-way round-robin arbiter.
- Each entry stores the granted payload (arbiter out bits) together with its source tag (arbiter chosen).
- Tracks per-source occupancy and drives a per-source block vector. The upstream side uses this vector to mask an input's valid, so no single source can fill the queue.
- Its output feeds the shared consumer.

---
 rtl/rr_grant_queue.sv | 108 ++++++++++
 tb/tb_rr_grant_queue.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_queue.sv
// rr_grant_queue: circular buffer placed after the 4-way round-robin arbiter.
// Each entry holds the granted payload and its source tag. The block tracks
// how many entries each source holds and flags sources at their limit.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   io_enq_*          arbiter side (valid/ready/bits/tag)
//   io_deq_*          consumer side (valid/ready/bits/tag)
//   io_count          entries held, 0..DEPTH
//   io_src_block      bit i set when source i holds MAX_PER_SRC entries
module rr_grant_queue #(
  parameter int DATA_W      = 8,
  parameter int NSRC        = 4,
  parameter int TAG_W       = 2,
  parameter int DEPTH       = 4,
  parameter int MAX_PER_SRC = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_enq_valid,
  output logic                       io_enq_ready,
  input  logic [DATA_W-1:0]          io_enq_bits,
  input  logic [TAG_W-1:0]           io_enq_tag,
  output logic                       io_deq_valid,
  input  logic                       io_deq_ready,
  output logic [DATA_W-1:0]          io_deq_bits,
  output logic [TAG_W-1:0]           io_deq_tag,
  output logic [$clog2(DEPTH):0]     io_count,
  output logic [NSRC-1:0]            io_src_block
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_PER_SRC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PER_SRC);

  logic [DATA_W+TAG_W-1:0] r_ram [DEPTH];
  logic [PTR_W-1:0]        r_enq_ptr;
  logic [PTR_W-1:0]        r_deq_ptr;
  logic                    r_maybe_full;
  logic [CNT_W-1:0]        r_src_cnt [NSRC];

  logic             w_ptr_match;
  logic             w_empty;
  logic             w_full;
  logic             w_enq_fire;
  logic             w_deq_fire;
  logic [PTR_W-1:0] w_diff;

  assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_full      = w_ptr_match & r_maybe_full;

  assign io_enq_ready = ~w_full;
  assign io_deq_valid = ~w_empty;
  assign w_enq_fire   = io_enq_valid & io_enq_ready;
  assign w_deq_fire   = io_deq_valid & io_deq_ready;

  assign {io_deq_tag, io_deq_bits} = r_ram[r_deq_ptr];

  assign w_diff   = r_enq_ptr - r_deq_ptr;
  assign io_count = w_full ? (PTR_W+1)'(DEPTH) : {1'b0, w_diff};

  always_ff @(posedge clk) begin
    if (w_enq_fire && !reset) begin
      r_ram[r_enq_ptr] <= {io_enq_tag, io_enq_bits};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_enq_fire) r_enq_ptr <= r_enq_ptr + 1'b1;
      if (w_deq_fire) r_deq_ptr <= r_deq_ptr + 1'b1;
      if (w_enq_fire != w_deq_fire) r_maybe_full <= w_enq_fire;
    end
  end

  // Saturates at MAX_PER_SRC on an unmasked overflow enq, and holds at zero
  // rather than wrapping once the count has drifted low after such an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        r_src_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NSRC; i++) begin
        if (w_enq_fire && (io_enq_tag == TAG_W'(i)) &&
            !(w_deq_fire && (io_deq_tag == TAG_W'(i)))) begin
          if (r_src_cnt[i] != CNT_MAX) r_src_cnt[i] <= r_src_cnt[i] + 1'b1;
        end else if (w_deq_fire && (io_deq_tag == TAG_W'(i)) &&
                     !(w_enq_fire && (io_enq_tag == TAG_W'(i)))) begin
          if (r_src_cnt[i] != '0) r_src_cnt[i] <= r_src_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    io_src_block = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      io_src_block[i] = (r_src_cnt[i] == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_rr_grant_queue.sv
module tb_rr_grant_queue;

  logic       clk;
  logic       reset;
  logic       io_enq_valid;
  logic       io_enq_ready;
  logic [7:0] io_enq_bits;
  logic [1:0] io_enq_tag;
  logic       io_deq_valid;
  logic       io_deq_ready;
  logic [7:0] io_deq_bits;
  logic [1:0] io_deq_tag;
  logic [2:0] io_count;
  logic [3:0] io_src_block;

  int n_cmp = 0;
  int n_err = 0;

  rr_grant_queue #(
    .DATA_W(8),
    .NSRC(4),
    .TAG_W(2),
    .DEPTH(4),
    .MAX_PER_SRC(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_enq_valid(io_enq_valid),
    .io_enq_ready(io_enq_ready),
    .io_enq_bits(io_enq_bits),
    .io_enq_tag(io_enq_tag),
    .io_deq_valid(io_deq_valid),
    .io_deq_ready(io_deq_ready),
    .io_deq_bits(io_deq_bits),
    .io_deq_tag(io_deq_tag),
    .io_count(io_count),
    .io_src_block(io_src_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_enq_valid = 1'b0;
    io_enq_bits = '0;
    io_enq_tag = '0;
    io_deq_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (io_deq_valid !== 1'b0) begin n_err++; $display("FAIL reset_deq_valid got %b exp 0", io_deq_valid); end
    n_cmp++; if (io_enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_enq_ready got %b exp 1", io_enq_ready); end
    n_cmp++; if (io_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", io_count); end
    n_cmp++; if (io_src_block !== 4'b0000) begin n_err++; $display("FAIL reset_block got %b exp 0000", io_src_block); end
  endtask

  task automatic test_latency();
    io_enq_valid = 1'b1; io_enq_bits = 8'h11; io_enq_tag = 2'd1; io_deq_ready = 1'b1;
    #1;
    n_cmp++; if (io_deq_valid !== 1'b0) begin n_err++; $display("FAIL lat_no_flow got %b exp 0", io_deq_valid); end
    tick();
    io_enq_valid = 1'b0;
    n_cmp++; if (io_deq_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid got %b exp 1", io_deq_valid); end
    n_cmp++; if (io_deq_bits !== 8'h11) begin n_err++; $display("FAIL lat_bits got %h exp 11", io_deq_bits); end
    n_cmp++; if (io_deq_tag !== 2'd1) begin n_err++; $display("FAIL lat_tag got %0d exp 1", io_deq_tag); end
    n_cmp++; if (io_count !== 3'd1) begin n_err++; $display("FAIL lat_count1 got %0d exp 1", io_count); end
    tick();
    n_cmp++; if (io_count !== 3'd0) begin n_err++; $display("FAIL lat_count0 got %0d exp 0", io_count); end
    n_cmp++; if (io_deq_valid !== 1'b0) begin n_err++; $display("FAIL lat_empty got %b exp 0", io_deq_valid); end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] exp_b;
    io_deq_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      io_enq_valid = 1'b1; io_enq_bits = 8'hA0 + 8'(k); io_enq_tag = 2'(k);
      tick();
    end
    n_cmp++; if (io_count !== 3'd4) begin n_err++; $display("FAIL fill_count got %0d exp 4", io_count); end
    n_cmp++; if (io_enq_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready got %b exp 0", io_enq_ready); end
    n_cmp++; if (io_src_block !== 4'b0000) begin n_err++; $display("FAIL fill_block got %b exp 0000", io_src_block); end
    io_enq_bits = 8'hFF; io_enq_tag = 2'd0;
    tick();
    n_cmp++; if (io_count !== 3'd4) begin n_err++; $display("FAIL fill_fifth got %0d exp 4", io_count); end
    io_enq_valid = 1'b0; io_deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_b = 8'hA0 + 8'(k);
      n_cmp++; if (io_deq_bits !== exp_b) begin n_err++; $display("FAIL drain_bits%0d got %h exp %h", k, io_deq_bits, exp_b); end
      n_cmp++; if (io_deq_tag !== 2'(k)) begin n_err++; $display("FAIL drain_tag%0d got %0d exp %0d", k, io_deq_tag, k); end
      tick();
    end
    n_cmp++; if (io_count !== 3'd0) begin n_err++; $display("FAIL drain_count got %0d exp 0", io_count); end
    n_cmp++; if (io_deq_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b exp 0", io_deq_valid); end
    io_deq_ready = 1'b0;
  endtask

  task automatic test_src_block();
    io_deq_ready = 1'b0;
    io_enq_valid = 1'b1; io_enq_tag = 2'd2; io_enq_bits = 8'h21;
    tick();
    n_cmp++; if (io_src_block !== 4'b0000) begin n_err++; $display("FAIL blk_one got %b exp 0000", io_src_block); end
    io_enq_bits = 8'h22;
    tick();
    io_enq_valid = 1'b0;
    n_cmp++; if (io_src_block !== 4'b0100) begin n_err++; $display("FAIL blk_set got %b exp 0100", io_src_block); end
    io_deq_ready = 1'b1;
    tick();
    io_deq_ready = 1'b0;
    n_cmp++; if (io_src_block !== 4'b0000) begin n_err++; $display("FAIL blk_clear got %b exp 0000", io_src_block); end
    n_cmp++; if (io_deq_bits !== 8'h22) begin n_err++; $display("FAIL blk_head got %h exp 22", io_deq_bits); end
    io_deq_ready = 1'b1;
    tick();
    io_deq_ready = 1'b0;
    n_cmp++; if (io_count !== 3'd0) begin n_err++; $display("FAIL blk_drain got %0d exp 0", io_count); end
  endtask

  task automatic test_overflow();
    io_deq_ready = 1'b0;
    io_enq_valid = 1'b1; io_enq_tag = 2'd1;
    for (int k = 0; k < 3; k++) begin
      io_enq_bits = 8'h40 + 8'(k);
      tick();
    end
    io_enq_valid = 1'b0;
    n_cmp++; if (io_count !== 3'd3) begin n_err++; $display("FAIL ovf_count got %0d exp 3", io_count); end
    n_cmp++; if (io_src_block !== 4'b0010) begin n_err++; $display("FAIL ovf_sat got %b exp 0010", io_src_block); end
    io_deq_ready = 1'b1;
    tick();
    n_cmp++; if (io_src_block !== 4'b0000) begin n_err++; $display("FAIL ovf_under got %b exp 0000", io_src_block); end
    tick();
    tick();
    io_deq_ready = 1'b0;
    n_cmp++; if (io_count !== 3'd0) begin n_err++; $display("FAIL ovf_drain got %0d exp 0", io_count); end
    n_cmp++; if (io_src_block !== 4'b0000) begin n_err++; $display("FAIL ovf_floor got %b exp 0000", io_src_block); end
  endtask

  task automatic test_full_enq_deq();
    io_deq_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      io_enq_valid = 1'b1; io_enq_bits = 8'hB0 + 8'(k); io_enq_tag = 2'(k);
      tick();
    end
    io_enq_bits = 8'hCC; io_enq_tag = 2'd0; io_deq_ready = 1'b1;
    tick();
    io_enq_valid = 1'b0;
    n_cmp++; if (io_count !== 3'd3) begin n_err++; $display("FAIL full_count got %0d exp 3", io_count); end
    n_cmp++; if (io_enq_ready !== 1'b1) begin n_err++; $display("FAIL full_ready got %b exp 1", io_enq_ready); end
    n_cmp++; if (io_deq_bits !== 8'hB1) begin n_err++; $display("FAIL full_head got %h exp b1", io_deq_bits); end
    tick();
    tick();
    n_cmp++; if (io_deq_bits !== 8'hB3) begin n_err++; $display("FAIL full_last got %h exp b3", io_deq_bits); end
    tick();
    io_deq_ready = 1'b0;
    n_cmp++; if (io_count !== 3'd0) begin n_err++; $display("FAIL full_drain got %0d exp 0", io_count); end
  endtask

  task automatic test_same_tag_and_reset();
    io_deq_ready = 1'b0;
    io_enq_valid = 1'b1; io_enq_tag = 2'd3; io_enq_bits = 8'h31;
    tick();
    io_enq_bits = 8'h32;
    tick();
    n_cmp++; if (io_src_block !== 4'b1000) begin n_err++; $display("FAIL same_pre got %b exp 1000", io_src_block); end
    io_enq_bits = 8'h33; io_deq_ready = 1'b1;
    tick();
    n_cmp++; if (io_count !== 3'd2) begin n_err++; $display("FAIL same_count got %0d exp 2", io_count); end
    n_cmp++; if (io_src_block !== 4'b1000) begin n_err++; $display("FAIL same_block got %b exp 1000", io_src_block); end
    n_cmp++; if (io_deq_bits !== 8'h32) begin n_err++; $display("FAIL same_head got %h exp 32", io_deq_bits); end
    reset = 1'b1;
    tick();
    n_cmp++; if (io_count !== 3'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", io_count); end
    n_cmp++; if (io_deq_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", io_deq_valid); end
    n_cmp++; if (io_src_block !== 4'b0000) begin n_err++; $display("FAIL rst_block got %b exp 0000", io_src_block); end
    reset = 1'b0; io_enq_valid = 1'b0; io_deq_ready = 1'b0;
    tick();
    n_cmp++; if (io_count !== 3'd0) begin n_err++; $display("FAIL post_rst_count got %0d exp 0", io_count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_wrap();
    test_src_block();
    test_overflow();
    test_full_enq_deq();
    test_same_tag_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
